// File: rtl/rv_wb_arbiter.sv
// Writeback arbiter for the multi-hart register file: ALU/LSU result merge,
// LSU result FIFO, and a per-hart pending-write scoreboard for issue hazards.
module rv_wb_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int LSU_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [4:0]            alu_rd,
  input  logic [2:0]            alu_hart,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [4:0]            lsu_rd,
  input  logic [2:0]            lsu_hart,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_we,
  output logic                  rf_en,
  output logic [4:0]            rf_rd,
  output logic [2:0]            rf_hart,
  output logic [DATA_WIDTH-1:0] rf_data,
  input  logic                  issue_mark,
  input  logic [4:0]            issue_rd,
  input  logic [2:0]            issue_hart,
  input  logic [2:0]            chk_hart,
  input  logic [4:0]            chk_rs1,
  input  logic [4:0]            chk_rs2,
  input  logic [4:0]            chk_rd,
  output logic                  chk_busy
);

  localparam int PTR_W = $clog2(LSU_FIFO_DEPTH);

  typedef struct packed {
    logic [2:0]            hart;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_t;

  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_LSU} src_e;

  wb_t              fifo_mem [LSU_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  src_e             src;
  wb_t              win;
  logic [255:0]     pending, pending_nxt;

  assign fifo_full  = (count == (PTR_W+1)'(LSU_FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign alu_ready  = !fifo_full;
  assign lsu_ready  = !fifo_full;
  assign push       = lsu_valid && lsu_ready;
  assign pop        = (src == SRC_LSU);

  // A full FIFO takes priority so the LSU can never be starved by a busy ALU.
  always_comb begin
    src = SRC_NONE;
    win = '0;
    if (fifo_full) begin
      src = SRC_LSU;
    end else if (alu_valid) begin
      src = SRC_ALU;
    end else if (!fifo_empty) begin
      src = SRC_LSU;
    end
    case (src)
      SRC_ALU: win = '{hart: alu_hart, rd: alu_rd, data: alu_data};
      SRC_LSU: win = fifo_mem[rd_ptr];
      default: win = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // NOTE: FIFO storage is not reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{hart: lsu_hart, rd: lsu_rd, data: lsu_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we   <= 1'b0;
      rf_rd   <= '0;
      rf_hart <= '0;
      rf_data <= '0;
    end else begin
      rf_we <= (src != SRC_NONE) && (win.rd != 5'd0);
      if (src != SRC_NONE) begin
        rf_rd   <= win.rd;
        rf_hart <= win.hart;
        rf_data <= win.data;
      end
    end
  end

  assign rf_en = rf_we;

  // Clear first, then set, so a newly issued writer of the same register wins.
  always_comb begin
    // NOTE: default first and blocking assignments here keep this purely combinational (no latch).
    pending_nxt = pending;
    if (src != SRC_NONE) pending_nxt[{win.hart, win.rd}] = 1'b0;
    if (issue_mark && (issue_rd != 5'd0)) pending_nxt[{issue_hart, issue_rd}] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign chk_busy = pending[{chk_hart, chk_rs1}] | pending[{chk_hart, chk_rs2}] |
                    pending[{chk_hart, chk_rd}];

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Self-checking bench for rv_wb_arbiter: table-driven ALU writes, a tagged
// per-source write scoreboard, and directed contention/collision/reset sequences.
module tb_rv_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [2:0]  alu_hart;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [2:0]  lsu_hart;
  logic [31:0] lsu_data;
  logic        rf_we, rf_en;
  logic [4:0]  rf_rd;
  logic [2:0]  rf_hart;
  logic [31:0] rf_data;
  logic        issue_mark;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_hart;
  logic [2:0]  chk_hart;
  logic [4:0]  chk_rs1, chk_rs2, chk_rd;
  logic        chk_busy;

  rv_wb_arbiter #(.DATA_WIDTH(32), .LSU_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
    .alu_hart(alu_hart), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
    .lsu_hart(lsu_hart), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_en(rf_en), .rf_rd(rf_rd), .rf_hart(rf_hart), .rf_data(rf_data),
    .issue_mark(issue_mark), .issue_rd(issue_rd), .issue_hart(issue_hart),
    .chk_hart(chk_hart), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .chk_busy(chk_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Expected writes per source, {hart, rd, data}; LSU data is tagged 0x5xxxxxxx.
  logic [39:0] alu_q[$];
  logic [39:0] lsu_q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      alu_q.delete();
      lsu_q.delete();
    end else begin
      if (alu_valid && alu_ready && alu_rd != 5'd0) alu_q.push_back({alu_hart, alu_rd, alu_data});
      if (lsu_valid && lsu_ready && lsu_rd != 5'd0) lsu_q.push_back({lsu_hart, lsu_rd, lsu_data});
    end
  end

  always @(negedge clk) begin
    logic [39:0] e;
    check("rf_en_tracks_we", rf_en, rf_we);
    if (rf_we) begin
      if (rf_data[31:28] == 4'h5) begin
        if (lsu_q.size() == 0) begin
          total++; bad++;
          $display("FAIL lsu_write: got unexpected %0h want none", {rf_hart, rf_rd, rf_data});
        end else begin
          e = lsu_q.pop_front();
          check("lsu_write", {rf_hart, rf_rd, rf_data}, e);
        end
      end else begin
        if (alu_q.size() == 0) begin
          total++; bad++;
          $display("FAIL alu_write: got unexpected %0h want none", {rf_hart, rf_rd, rf_data});
        end else begin
          e = alu_q.pop_front();
          check("alu_write", {rf_hart, rf_rd, rf_data}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  hart;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exp_busy;
    logic        exp_we;
  } alu_vec_t;

  alu_vec_t vecs[5];

  task automatic set_chk(input logic [2:0] h, input logic [4:0] r);
    chk_hart = h; chk_rs1 = r; chk_rs2 = 5'd0; chk_rd = 5'd0;
    settle();
  endtask

  task automatic set_alu(input int i);
    alu_hart = 3'(i);
    alu_rd   = 5'((i % 31) + 1);
    alu_data = 32'hA000_0000 | 32'(i);
  endtask

  initial begin
    int pulses;
    vecs[0] = '{hart: 3'd3, rd: 5'd5,  data: 32'hDEAD_BEEF, exp_busy: 1'b1, exp_we: 1'b1};
    vecs[1] = '{hart: 3'd0, rd: 5'd1,  data: 32'hA000_0001, exp_busy: 1'b1, exp_we: 1'b1};
    vecs[2] = '{hart: 3'd7, rd: 5'd31, data: 32'hFFFF_FFFF, exp_busy: 1'b1, exp_we: 1'b1};
    vecs[3] = '{hart: 3'd2, rd: 5'd0,  data: 32'h0000_1234, exp_busy: 1'b0, exp_we: 1'b0};
    vecs[4] = '{hart: 3'd5, rd: 5'd16, data: 32'h0000_0000, exp_busy: 1'b1, exp_we: 1'b1};

    rst_n = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_hart = 3'd3; alu_data = 32'hDEAD_BEEF;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_hart = '0; lsu_data = '0;
    issue_mark = 1'b0; issue_rd = '0; issue_hart = '0;
    chk_hart = '0; chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;

    // Reset with ALU valid: nothing is written and no register is pending.
    tick(); tick();
    check("reset_rf_we", rf_we, 1'b0);
    check("reset_rf_data", rf_data, 32'h0);
    check("reset_rf_rd", rf_rd, 5'd0);
    check("reset_rf_hart", rf_hart, 3'd0);
    for (int h = 0; h < 8; h++) begin
      chk_hart = 3'(h); chk_rs1 = 5'(h * 4 + 1); chk_rs2 = 5'(31 - h); chk_rd = 5'(h + 8);
      settle();
      check("reset_chk_busy", chk_busy, 1'b0);
    end
    alu_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_reset_alu_ready", alu_ready, 1'b1);
    check("post_reset_lsu_ready", lsu_ready, 1'b1);

    // Table-driven ALU writes with scoreboard mark/clear.
    for (int i = 0; i < 5; i++) begin
      set_chk(vecs[i].hart, vecs[i].rd);
      check("vec_busy_before_mark", chk_busy, 1'b0);
      issue_mark = 1'b1; issue_hart = vecs[i].hart; issue_rd = vecs[i].rd;
      tick();
      issue_mark = 1'b0;
      settle();
      check("vec_busy_marked", chk_busy, vecs[i].exp_busy);
      alu_valid = 1'b1; alu_hart = vecs[i].hart; alu_rd = vecs[i].rd; alu_data = vecs[i].data;
      settle();
      check("vec_alu_ready", alu_ready, 1'b1);
      tick();
      alu_valid = 1'b0;
      settle();
      check("vec_rf_we", rf_we, vecs[i].exp_we);
      check("vec_rf_fields", {rf_hart, rf_rd, rf_data}, {vecs[i].hart, vecs[i].rd, vecs[i].data});
      check("vec_busy_cleared", chk_busy, 1'b0);
    end
    tick();
    check("idle_rf_we", rf_we, 1'b0);
    check("idle_rf_hold", rf_data, 32'h0000_0000);

    // LSU latency: enqueue at N, pop at N+1, write visible after N+1.
    issue_mark = 1'b1; issue_hart = 3'd4; issue_rd = 5'd9;
    tick();
    issue_mark = 1'b0;
    lsu_valid = 1'b1; lsu_hart = 3'd4; lsu_rd = 5'd9; lsu_data = 32'h5000_0099;
    tick();
    lsu_valid = 1'b0;
    set_chk(3'd4, 5'd9);
    check("lsu_lat_no_we_n", rf_we, 1'b0);
    check("lsu_lat_busy", chk_busy, 1'b1);
    tick();
    check("lsu_lat_we", rf_we, 1'b1);
    check("lsu_lat_data", rf_data, 32'h5000_0099);
    check("lsu_lat_busy_cleared", chk_busy, 1'b0);
    tick();

    // Contention: ALU always valid, four LSU results fill the FIFO.
    alu_valid = 1'b1;
    lsu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_alu(i + 16);
      lsu_hart = 3'(i); lsu_rd = 5'(i + 20); lsu_data = 32'h5000_0100 | 32'(i);
      settle();
      check("fill_lsu_ready", lsu_ready, 1'b1);
      tick();
    end
    lsu_valid = 1'b0;
    set_alu(40);
    settle();
    check("full_lsu_ready", lsu_ready, 1'b0);
    check("full_alu_ready", alu_ready, 1'b0);
    tick();
    check("full_head_written", {rf_we, rf_data}, {1'b1, 32'h5000_0100});
    check("after_pop_alu_ready", alu_ready, 1'b1);
    for (int i = 0; i < 2; i++) begin
      set_alu(41 + i);
      tick();
    end
    alu_valid = 1'b0;
    for (int i = 0; i < 12 && (alu_q.size() != 0 || lsu_q.size() != 0); i++) tick();
    tick();
    check("drain_alu_q", alu_q.size(), 0);
    check("drain_lsu_q", lsu_q.size(), 0);

    // Set/clear collision on hart 1 rd 7: the new mark survives.
    issue_mark = 1'b1; issue_hart = 3'd1; issue_rd = 5'd7;
    tick();
    alu_valid = 1'b1; alu_hart = 3'd1; alu_rd = 5'd7; alu_data = 32'h0000_0077;
    tick();
    alu_valid = 1'b0; issue_mark = 1'b0;
    set_chk(3'd1, 5'd7);
    check("collide_we", rf_we, 1'b1);
    check("collide_busy", chk_busy, 1'b1);
    alu_valid = 1'b1; alu_data = 32'h0000_0078;
    tick();
    alu_valid = 1'b0;
    settle();
    check("collide_second_clear", chk_busy, 1'b0);
    tick();

    // Mid-operation reset with three LSU results buffered.
    issue_mark = 1'b1; issue_hart = 3'd6; issue_rd = 5'd3;
    tick();
    issue_rd = 5'd4;
    tick();
    issue_mark = 1'b0;
    alu_valid = 1'b1;
    lsu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_alu(60 + i);
      lsu_hart = 3'd6; lsu_rd = 5'(3 + i); lsu_data = 32'h5000_0200 | 32'(i);
      tick();
    end
    lsu_valid = 1'b0;
    alu_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("midrst_rf_we", rf_we, 1'b0);
    check("midrst_rf_data", rf_data, 32'h0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rf_we) pulses++;
    end
    check("midrst_no_writes", pulses, 0);
    chk_hart = 3'd6; chk_rs1 = 5'd3; chk_rs2 = 5'd4; chk_rd = 5'd5;
    settle();
    check("midrst_pending_cleared", chk_busy, 1'b0);
    check("midrst_ready", {alu_ready, lsu_ready}, 2'b11);
    check("final_alu_q", alu_q.size(), 0);
    check("final_lsu_q", lsu_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
